// File: rtl/adma_pkg.sv
// Shared types and constants for the ADMA2 descriptor fetch engine:
// FSM states, descriptor act codes, word0 field positions and address strides.
package adma_pkg;

    typedef enum logic [2:0] {
        ST_STOP,
        ST_FDS0,
        ST_FDS1,
        ST_CADR,
        ST_TFR,
        ST_WAIT,
        ST_ERR
    } adma_state_t;

    localparam logic [1:0] ACT_NOP  = 2'b00;
    localparam logic [1:0] ACT_RSV  = 2'b01;
    localparam logic [1:0] ACT_TRAN = 2'b10;
    localparam logic [1:0] ACT_LINK = 2'b11;

    localparam int W0_VALID   = 0;
    localparam int W0_END     = 1;
    localparam int W0_INT     = 2;
    localparam int W0_ACT_LSB = 4;
    localparam int W0_LEN_LSB = 16;

    // Addresses are bit addresses: one 32-bit word spans 32 units.
    localparam int WORD_STRIDE = 32;
    localparam int DESC_STRIDE = 64;
    localparam int ALIGN_BITS  = 5;

    function automatic logic is_aligned(input logic [ALIGN_BITS-1:0] low_bits);
        return low_bits == '0;
    endfunction

endpackage

// File: rtl/adma_desc_fetch_if.sv
// Memory read port and transfer-command handshake of the descriptor fetcher.
// master = fetch engine side, slave = memory / data transfer engine side.
interface adma_desc_fetch_if #(
    parameter int ADDR_W = 64
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_write;
    logic [31:0]       mem_data_in;
    logic [31:0]       mem_data_out;

    logic              xfer_valid;
    logic              xfer_ready;
    logic [ADDR_W-1:0] xfer_addr;
    logic [16:0]       xfer_len;
    logic              xfer_done;

    modport master (
        output mem_address, mem_write, mem_data_in,
        input  mem_data_out,
        output xfer_valid, xfer_addr, xfer_len,
        input  xfer_ready, xfer_done
    );

    modport slave (
        input  mem_address, mem_write, mem_data_in,
        output mem_data_out,
        input  xfer_valid, xfer_addr, xfer_len,
        output xfer_ready, xfer_done
    );
endinterface

// File: rtl/adma_desc_decode.sv
// Combinational split of a latched ADMA2 descriptor into its attribute fields,
// the byte length (0 encodes 65536) and the LINK-target alignment check.
module adma_desc_decode
    import adma_pkg::*;
(
    input  logic [31:0] word0_i,
    input  logic [31:0] word1_i,
    output logic        valid_o,
    output logic        end_o,
    output logic        int_o,
    output logic [1:0]  act_o,
    output logic [16:0] xfer_len_o,
    output logic        link_aligned_o
);
    logic [15:0] len_field;
    logic        unused_bits;

    assign valid_o        = word0_i[W0_VALID];
    assign end_o          = word0_i[W0_END];
    assign int_o          = word0_i[W0_INT];
    assign act_o          = word0_i[W0_ACT_LSB +: 2];
    assign len_field      = word0_i[W0_LEN_LSB +: 16];
    assign xfer_len_o     = (len_field == 16'h0) ? 17'h1_0000 : {1'b0, len_field};
    assign link_aligned_o = is_aligned(word1_i[ALIGN_BITS-1:0]);

    // Reserved word0 bits and the upper word1 bits carry nothing for decode.
    assign unused_bits = ^{word0_i[15:6], word0_i[3], word1_i[31:ALIGN_BITS]};

endmodule

// File: rtl/adma_desc_fetch.sv
// ADMA2 descriptor table walker: fetches two-word descriptors, issues TRAN commands,
// follows LINKs, stops on END. Optional ADMA_INT_EN enables the adma_int pulse.
module adma_desc_fetch
    import adma_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] desc_base,
    adma_desc_fetch_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr,
    output logic              adma_int
);
`ifdef ADMA_INT_EN
    localparam logic INT_EN = 1'b1;
`else
    localparam logic INT_EN = 1'b0;
`endif

    adma_state_t       state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [31:0]       word0_q;
    logic [31:0]       word1_q;
    logic              xfer_valid_q;
    logic [ADDR_W-1:0] xfer_addr_q;
    logic [16:0]       xfer_len_q;
    logic              done_q;
    logic              error_q;
    logic [ADDR_W-1:0] err_addr_q;
    logic              adma_int_q;

    logic              d_valid;
    logic              d_end;
    logic              d_int;
    logic [1:0]        d_act;
    logic [16:0]       d_len;
    logic              d_link_aligned;
    logic [ADDR_W-1:0] ptr_next_desc;
    logic [ADDR_W-1:0] ptr_word1;
    logic [ADDR_W-1:0] link_ptr;

    adma_desc_decode u_decode (
        .word0_i        (word0_q),
        .word1_i        (word1_q),
        .valid_o        (d_valid),
        .end_o          (d_end),
        .int_o          (d_int),
        .act_o          (d_act),
        .xfer_len_o     (d_len),
        .link_aligned_o (d_link_aligned)
    );

    assign ptr_next_desc = ptr_q + ADDR_W'(DESC_STRIDE);
    assign ptr_word1     = ptr_q + ADDR_W'(WORD_STRIDE);
    assign link_ptr      = ADDR_W'(word1_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_STOP;
            ptr_q         <= '0;
            mem_address_q <= '0;
            word0_q       <= '0;
            word1_q       <= '0;
            xfer_valid_q  <= 1'b0;
            xfer_addr_q   <= '0;
            xfer_len_q    <= '0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            err_addr_q    <= '0;
            adma_int_q    <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            adma_int_q <= 1'b0;
            case (state_q)
                ST_STOP, ST_ERR: begin
                    if (start) begin
                        ptr_q   <= desc_base;
                        error_q <= 1'b0;
                        if (is_aligned(desc_base[ALIGN_BITS-1:0])) begin
                            mem_address_q <= desc_base;
                            state_q       <= ST_FDS0;
                        end else begin
                            error_q    <= 1'b1;
                            err_addr_q <= desc_base;
                            state_q    <= ST_ERR;
                        end
                    end
                end
                ST_FDS0: begin
                    word0_q       <= bus.mem_data_out;
                    mem_address_q <= ptr_word1;
                    state_q       <= ST_FDS1;
                end
                ST_FDS1: begin
                    word1_q <= bus.mem_data_out;
                    state_q <= ST_CADR;
                end
                ST_CADR: begin
                    if (!d_valid) begin
                        error_q    <= 1'b1;
                        err_addr_q <= ptr_q;
                        state_q    <= ST_ERR;
                    end else begin
                        case (d_act)
                            ACT_LINK: begin
                                // The end bit of a LINK is deliberately not examined.
                                ptr_q <= link_ptr;
                                if (d_link_aligned) begin
                                    mem_address_q <= link_ptr;
                                    state_q       <= ST_FDS0;
                                end else begin
                                    error_q    <= 1'b1;
                                    err_addr_q <= ptr_q;
                                    state_q    <= ST_ERR;
                                end
                            end
                            ACT_TRAN: begin
                                xfer_valid_q <= 1'b1;
                                xfer_addr_q  <= link_ptr;
                                xfer_len_q   <= d_len;
                                state_q      <= ST_TFR;
                            end
                            ACT_NOP, ACT_RSV: begin
                                adma_int_q <= INT_EN & d_int & (d_act == ACT_NOP);
                                if (d_end) begin
                                    done_q  <= 1'b1;
                                    state_q <= ST_STOP;
                                end else begin
                                    ptr_q         <= ptr_next_desc;
                                    mem_address_q <= ptr_next_desc;
                                    state_q       <= ST_FDS0;
                                end
                            end
                            default: state_q <= ST_ERR;
                        endcase
                    end
                end
                ST_TFR: begin
                    if (bus.xfer_ready) begin
                        xfer_valid_q <= 1'b0;
                        state_q      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.xfer_done) begin
                        adma_int_q <= INT_EN & d_int;
                        if (d_end) begin
                            done_q  <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            ptr_q         <= ptr_next_desc;
                            mem_address_q <= ptr_next_desc;
                            state_q       <= ST_FDS0;
                        end
                    end
                end
                default: state_q <= ST_STOP;
            endcase
        end
    end

    assign bus.mem_address = mem_address_q;
    assign bus.mem_write   = 1'b0;
    assign bus.mem_data_in = 32'h0;
    assign bus.xfer_valid  = xfer_valid_q;
    assign bus.xfer_addr   = xfer_addr_q;
    assign bus.xfer_len    = xfer_len_q;

    assign busy     = (state_q != ST_STOP) && (state_q != ST_ERR);
    assign done     = done_q;
    assign error    = error_q;
    assign err_addr = err_addr_q;
    assign adma_int = adma_int_q;

endmodule

// File: tb/tb_adma_desc_fetch.sv
// Self-checking bench for adma_desc_fetch: directed scenarios plus randomized
// descriptor tables checked against a table-walking reference model.
module tb_adma_desc_fetch;
    localparam int ADDR_W    = 64;
    localparam int MEM_WORDS = 2048;
`ifdef ADMA_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] desc_base = '0;
    logic              busy, done, error, adma_int;
    logic [ADDR_W-1:0] err_addr;

    adma_desc_fetch_if #(.ADDR_W(ADDR_W)) bus ();

    adma_desc_fetch #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .desc_base (desc_base),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_addr  (err_addr),
        .adma_int  (adma_int)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Word-addressed system memory seen through a bit-addressed port.
    logic [31:0] mem [MEM_WORDS];
    always_comb begin
        bus.mem_data_out = 32'h0;
        if (bus.mem_address < 64'(MEM_WORDS * 32))
            bus.mem_data_out = mem[bus.mem_address[15:5]];
    end

    // ---------------- reference model ----------------
    logic [63:0] exp_addr_q[$];
    logic [16:0] exp_len_q[$];
    logic [63:0] exp_fetch_q[$];
    bit          exp_error;
    logic [63:0] exp_err_addr;
    int          exp_ints;
    int          exp_dones;

    function automatic logic [31:0] rd(input logic [63:0] a);
        if (a >= 64'(MEM_WORDS * 32)) return 32'h0;
        return mem[a[15:5]];
    endfunction

    function automatic void push_fetch(input logic [63:0] a);
        if (exp_fetch_q.size() == 0 || exp_fetch_q[$] != a) exp_fetch_q.push_back(a);
    endfunction

    function automatic void model_walk(input logic [63:0] base);
        logic [63:0] ptr;
        logic [31:0] w0, w1;
        int          len;
        exp_addr_q.delete(); exp_len_q.delete(); exp_fetch_q.delete();
        exp_error = 0; exp_err_addr = 0; exp_ints = 0; exp_dones = 0;
        if (base % 32 != 0) begin
            exp_error = 1; exp_err_addr = base; return;
        end
        ptr = base;
        for (int n = 0; n < 256; n++) begin
            w0 = rd(ptr);
            w1 = rd(ptr + 32);
            push_fetch(ptr);
            push_fetch(ptr + 32);
            if (w0[0] == 1'b0) begin
                exp_error = 1; exp_err_addr = ptr; return;
            end
            if (w0[5:4] == 2'b11) begin
                if (w1 % 32 != 0) begin
                    exp_error = 1; exp_err_addr = ptr; return;
                end
                ptr = 64'(w1);
                continue;
            end
            if (w0[5:4] == 2'b10) begin
                len = int'(w0[31:16]);
                if (len == 0) len = 65536;
                exp_addr_q.push_back(64'(w1));
                exp_len_q.push_back(17'(len));
            end
            if (w0[2] && w0[5:4] != 2'b01) exp_ints++;
            if (w0[1]) begin
                exp_dones = 1; return;
            end
            ptr = ptr + 64;
        end
    endfunction

    // ---------------- table helpers ----------------
    function automatic void clear_mem();
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0;
    endfunction

    function automatic void put_desc(input logic [63:0] a, input logic [31:0] w0, input logic [31:0] w1);
        logic [63:0] a1;
        a1 = a + 32;
        mem[a[15:5]]  = w0;
        mem[a1[15:5]] = w1;
    endfunction

    function automatic logic [31:0] mk_w0(input bit v, input bit e, input bit i,
                                           input logic [1:0] act, input logic [15:0] len);
        logic [31:0] r;
        r = $urandom;  // reserved bits get junk
        r[0] = v; r[1] = e; r[2] = i; r[5:4] = act; r[31:16] = len;
        return r;
    endfunction

    // ---------------- walk driver ----------------
    task automatic run_walk(input logic [63:0] base, input string name);
        logic [63:0] got_fetch_q[$];
        int dones = 0, ints = 0, ncmd = 0, done_wait = -1, cyc;
        bit fetch_bad = 0;
        model_walk(base);
        bus.xfer_ready = 0; bus.xfer_done = 0;
        @(negedge clk); desc_base = base; start = 1;
        @(negedge clk); start = 0;
        for (cyc = 0; cyc < 2000; cyc++) begin
            if (done) dones++;
            if (adma_int) ints++;
            if (!busy) break;
            if (got_fetch_q.size() == 0 || got_fetch_q[$] != bus.mem_address)
                got_fetch_q.push_back(bus.mem_address);
            bus.xfer_done = 0;
            if (done_wait > 0) begin
                done_wait--;
                if (done_wait == 0) begin bus.xfer_done = 1; done_wait = -1; end
            end
            if (bus.xfer_valid) begin
                bus.xfer_ready = ($urandom_range(0, 3) != 0);
                if (!bus.xfer_ready && $urandom_range(0, 3) == 0) bus.xfer_done = 1;
                if (bus.xfer_ready) begin
                    n_checks++;
                    if (exp_addr_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL %s unexpected_cmd: got addr=%h len=%0d, required none", name, bus.xfer_addr, bus.xfer_len);
                    end else begin
                        logic [63:0] ea;
                        logic [16:0] el;
                        ea = exp_addr_q.pop_front();
                        el = exp_len_q.pop_front();
                        $display("[%s] cmd %0d addr=%h len=%0d", name, ncmd, bus.xfer_addr, bus.xfer_len);
                        if (bus.xfer_addr !== ea || bus.xfer_len !== el) begin
                            n_errors++;
                            $display("FAIL %s cmd%0d: got addr=%h len=%0d, required addr=%h len=%0d",
                                     name, ncmd, bus.xfer_addr, bus.xfer_len, ea, el);
                        end
                    end
                    ncmd++;
                    done_wait = $urandom_range(1, 5);
                    if ($urandom_range(0, 2) == 0) bus.xfer_done = 1;
                end
            end else begin
                bus.xfer_ready = $urandom_range(0, 1);
            end
            @(negedge clk);
        end
        bus.xfer_ready = 0; bus.xfer_done = 0;
        n_checks++;
        if (cyc >= 2000) begin
            n_errors++;
            $display("FAIL %s timeout: busy still %b after 2000 cycles, required 0", name, busy);
        end
        @(negedge clk);
        if (done) dones++;
        if (adma_int) ints++;
        n_checks++;
        if (error !== exp_error) begin
            n_errors++;
            $display("FAIL %s error: got %b required %b", name, error, exp_error);
        end
        if (exp_error) begin
            n_checks++;
            if (err_addr !== exp_err_addr) begin
                n_errors++;
                $display("FAIL %s err_addr: got %h required %h", name, err_addr, exp_err_addr);
            end
        end
        n_checks++;
        if (dones !== exp_dones) begin
            n_errors++;
            $display("FAIL %s done_pulses: got %0d required %0d", name, dones, exp_dones);
        end
        n_checks++;
        if (ints !== (INT_EN ? exp_ints : 0)) begin
            n_errors++;
            $display("FAIL %s int_pulses: got %0d required %0d", name, ints, INT_EN ? exp_ints : 0);
        end
        n_checks++;
        if (exp_addr_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s missing_cmds: got %0d commands, required %0d more", name, ncmd, exp_addr_q.size());
        end
        n_checks++;
        if (got_fetch_q.size() != exp_fetch_q.size()) fetch_bad = 1;
        else for (int i = 0; i < got_fetch_q.size(); i++)
            if (got_fetch_q[i] !== exp_fetch_q[i]) fetch_bad = 1;
        if (fetch_bad) begin
            n_errors++;
            $display("FAIL %s fetch_addrs: got %0d addrs (first %h), required %0d (first %h)", name,
                     got_fetch_q.size(), got_fetch_q.size() ? got_fetch_q[0] : 64'h0,
                     exp_fetch_q.size(), exp_fetch_q.size() ? exp_fetch_q[0] : 64'h0);
        end
        $display("[%s] walk base=%h cmds=%0d done=%0d error=%b err_addr=%h", name, base, ncmd, dones, error, err_addr);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 20 && !bus.xfer_valid; i++) @(negedge clk);
        n_checks++;
        if (bus.xfer_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL %s wait_valid: xfer_valid got %b within 20 cycles, required 1", name, bus.xfer_valid);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, error, adma_int, bus.xfer_valid, bus.mem_write} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_flags: got busy,done,error,int,valid,wr=%b required 000000",
                     {busy, done, error, adma_int, bus.xfer_valid, bus.mem_write});
        end
        n_checks++;
        if (bus.mem_address !== '0 || bus.xfer_addr !== '0 || bus.xfer_len !== '0 ||
            err_addr !== '0 || bus.mem_data_in !== '0) begin
            n_errors++;
            $display("FAIL reset_buses: got mem_addr=%h xfer_addr=%h len=%h err_addr=%h din=%h required all 0",
                     bus.mem_address, bus.xfer_addr, bus.xfer_len, err_addr, bus.mem_data_in);
        end
        reset_n = 1;
        @(negedge clk);
        $display("[reset] done");
    endtask

    task automatic test_latency();
        clear_mem();
        put_desc(0, 32'h0010_0023, 32'h0000_0400);
        bus.xfer_ready = 0; bus.xfer_done = 0;
        desc_base = 0; start = 1;
        @(negedge clk); start = 0;   // cycle N+1
        n_checks++;
        if (bus.mem_address !== 64'd0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL lat_fds0: got addr=%h busy=%b required 0 and 1", bus.mem_address, busy);
        end
        @(negedge clk);              // N+2
        n_checks++;
        if (bus.mem_address !== 64'd32) begin
            n_errors++;
            $display("FAIL lat_fds1: got addr=%h required 20", bus.mem_address);
        end
        @(negedge clk);              // N+3
        n_checks++;
        if (bus.xfer_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL lat_cadr: xfer_valid got %b required 0", bus.xfer_valid);
        end
        @(negedge clk);              // N+4
        n_checks++;
        if (bus.xfer_valid !== 1'b1 || bus.xfer_addr !== 64'h400 || bus.xfer_len !== 17'd16) begin
            n_errors++;
            $display("FAIL lat_cmd: got valid=%b addr=%h len=%0d required 1 400 16",
                     bus.xfer_valid, bus.xfer_addr, bus.xfer_len);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.xfer_valid !== 1'b1 || bus.xfer_len !== 17'd16) begin
            n_errors++;
            $display("FAIL lat_hold: got valid=%b len=%0d required 1 16", bus.xfer_valid, bus.xfer_len);
        end
        bus.xfer_ready = 1;
        @(negedge clk); bus.xfer_ready = 0;
        n_checks++;
        if (bus.xfer_valid !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL lat_accept: got valid=%b busy=%b required 0 1", bus.xfer_valid, busy);
        end
        bus.xfer_done = 1;
        @(negedge clk); bus.xfer_done = 0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL lat_done: got done=%b busy=%b required 1 0", done, busy);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_errors++;
            $display("FAIL lat_done_pulse: done got %b required 0", done);
        end
        $display("[latency] single TRAN+END walk complete");
    endtask

    task automatic test_two_tran();
        clear_mem();
        put_desc(0,  32'h0010_0021, 32'h0000_0500);
        put_desc(64, 32'h0000_0023, 32'h0000_0800);
        run_walk(0, "two_tran");
    endtask

    task automatic test_link();
        clear_mem();
        put_desc(0,   32'h0010_0021, 32'h0000_0100);
        put_desc(64,  32'h0000_0033, 32'h0000_0100);  // LINK with end bit set
        put_desc(256, 32'h0010_0023, 32'h0000_0700);
        run_walk(0, "link");
    endtask

    task automatic test_errors();
        clear_mem();
        put_desc(0,  32'h0010_0021, 32'h0000_0100);
        put_desc(64, 32'h0010_0020, 32'h0000_0200);
        run_walk(0, "invalid");
        put_desc(512, 32'h0008_0023, 32'h0000_0300);
        run_walk(512, "restart");
        run_walk(40, "bad_base");
        clear_mem();
        put_desc(0, 32'h0000_0031, 32'h0000_0021);
        run_walk(0, "bad_link");
    endtask

    task automatic test_int_and_reset();
        clear_mem();
        put_desc(0, 32'h0010_0027, 32'h0000_0400);
        @(negedge clk); desc_base = 0; start = 1;
        @(negedge clk); start = 0;
        wait_valid("int");
        bus.xfer_ready = 1;
        @(negedge clk); bus.xfer_ready = 0;
        bus.xfer_done = 1;
        @(negedge clk); bus.xfer_done = 0;
        n_checks++;
        if (done !== 1'b1 || adma_int !== INT_EN || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL int_pulse: got done=%b int=%b busy=%b required 1 %b 0", done, adma_int, busy, INT_EN);
        end
        @(negedge clk);
        n_checks++;
        if (adma_int !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL int_once: got int=%b done=%b required 0 0", adma_int, done);
        end
        $display("[int] int=1 TRAN completed");
        // abort a walk while the transfer is outstanding
        desc_base = 0; start = 1;
        @(negedge clk); start = 0;
        wait_valid("reset_mid");
        bus.xfer_ready = 1;
        @(negedge clk); bus.xfer_ready = 0;
        reset_n = 0;
        #1;
        n_checks++;
        if ({busy, done, error, adma_int, bus.xfer_valid} !== 5'b0 || bus.mem_address !== '0 ||
            bus.xfer_addr !== '0 || bus.xfer_len !== '0 || err_addr !== '0) begin
            n_errors++;
            $display("FAIL reset_mid: got flags=%b mem_addr=%h xfer_addr=%h len=%h required all 0",
                     {busy, done, error, adma_int, bus.xfer_valid}, bus.mem_address, bus.xfer_addr, bus.xfer_len);
        end
        bus.xfer_done = 1;
        repeat (2) @(negedge clk);
        bus.xfer_done = 0;
        reset_n = 1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bus.mem_address !== '0) begin
            n_errors++;
            $display("FAIL reset_after: got busy=%b done=%b mem_addr=%h required 0 0 0", busy, done, bus.mem_address);
        end
        $display("[reset_mid] walk aborted");
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic [63:0] base, ptr, tgt;
            int n, k;
            clear_mem();
            base = 64'($urandom_range(0, 63)) * 32;
            if ($urandom_range(0, 9) == 0) base = base + 64'($urandom_range(1, 31));
            ptr = base;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n && base % 32 == 0; i++) begin
                bit last;
                logic [15:0] len;
                logic [1:0]  act;
                last = (i == n - 1);
                k = $urandom_range(0, 9);
                len = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
                if (!last && k < 2) begin
                    tgt = ptr + 64 + 64'($urandom_range(0, 8)) * 32;
                    put_desc(ptr, mk_w0(1, 1'($urandom), 1'($urandom), 2'b11, len), 32'(tgt));
                    ptr = tgt;
                end else begin
                    act = (k < 6) ? 2'b10 : (k < 8) ? 2'b00 : 2'b01;
                    if (last && $urandom_range(0, 5) == 0)
                        put_desc(ptr, mk_w0(0, 1, 1'($urandom), act, len), $urandom);
                    else if (last && $urandom_range(0, 5) == 0)
                        put_desc(ptr, mk_w0(1, 0, 0, 2'b11, len), 32'(ptr + 128 + 64'($urandom_range(1, 31))));
                    else
                        put_desc(ptr, mk_w0(1, last, 1'($urandom), act, len), $urandom);
                    ptr = ptr + 64;
                end
            end
            run_walk(base, $sformatf("rand%0d", t));
        end
    endtask

    initial begin
        bus.xfer_ready = 0;
        bus.xfer_done  = 0;
        clear_mem();
        test_reset();
        test_latency();
        test_two_tran();
        test_link();
        test_errors();
        test_int_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
